syncram_client: RTL and testbench

- Request-side initiator for the single-port synchronous RAM block (altsyncram interface: registered address/data/wren/byteena, read data valid one cycle after address capture).
- Converts a valid/ready request stream (read or byte-masked write) into RAM port cycles.
- Returns read data on a valid/ready response stream, buffered so that back-pressure never drops data.
- Optional post-reset clear sweep zeroes the whole RAM before requests are accepted. Sits between cache/DMA logic and the RAM instance.

---
 rtl/syncram_client_pkg.sv | 10 +
 rtl/syncram_client_if.sv | 26 ++
 rtl/syncram_rsp_fifo.sv | 63 ++++++
 rtl/syncram_client.sv | 106 ++++++++++
 tb/tb_syncram_client.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/syncram_client_pkg.sv
// Shared constants for the synchronous-RAM request client: FSM encoding,
// full byte mask and response buffer depth.
package syncram_client_pkg;

    localparam logic [0:0] ST_CLEAR    = 1'b0;
    localparam logic [0:0] ST_RUN      = 1'b1;
    localparam logic [3:0] BYTEENA_ALL = 4'hF;
    localparam int         RSP_DEPTH   = 2;

endpackage

// File: rtl/syncram_client_if.sv
// Request/response streams between cache/DMA logic (master) and the RAM
// client (slave): valid/ready on both directions.
interface syncram_client_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_byteena;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_byteena, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_byteena, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/syncram_rsp_fifo.sv
// Two-entry read-response FIFO; push lands in the tail register, head is a
// register (no flow-through). Caller guarantees no push into a full FIFO.
module syncram_rsp_fifo
    import syncram_client_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head_dat,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [RSP_DEPTH];
    logic [DATA_W-1:0] mem_d [RSP_DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_pop;
    logic              full;

    always_comb begin
        full     = (count_q == 2'(RSP_DEPTH));
        do_pop   = pop & (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

    a_no_overflow: assert property (@(posedge clock) disable iff (rst)
        !(push && full && !do_pop));

endmodule

// File: rtl/syncram_client.sv
// Turns a read/write request stream into altsyncram port cycles and returns
// read data in order through a 2-entry buffer; optional zeroing sweep after reset.
module syncram_client
    import syncram_client_pkg::*;
#(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 32,
    parameter int NUMWORDS       = 2048,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              rst,
    syncram_client_if.slave   req_if,
    output logic              ram_clocken,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic [3:0]        ram_byteena,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    localparam logic [0:0]        ST_AFTER_RST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W-1:0] CLR_LAST     = ADDR_W'(NUMWORDS - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        fifo_count;
    logic [2:0]        credit_used;
    logic              rsp_pop;
    logic              accept;
    logic              wr_accept;

    assign rsp_pop = req_if.rsp_valid & req_if.rsp_ready;

    // A pop at the same edge frees its slot, so streaming reads sustain one per cycle.
    assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, rsp_pop};
    assign req_if.req_ready = ~rst & (state_q == ST_RUN) & (credit_used < 3'(RSP_DEPTH));
    assign req_if.rsp_valid = (fifo_count != 2'd0);

    assign accept    = req_if.req_valid & req_if.req_ready;
    assign wr_accept = accept & req_if.req_write;
    assign busy      = (state_q == ST_CLEAR);

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        inflight_d = accept & ~req_if.req_write;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CLR_LAST) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= ST_AFTER_RST;
            clr_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    // The RAM registers its port, so drive it straight from the accepted request.
    always_comb begin
        if (state_q == ST_CLEAR) begin
            ram_wren    = 1'b1;
            ram_address = clr_cnt_q;
            ram_data    = '0;
            ram_byteena = BYTEENA_ALL;
        end else begin
            ram_wren    = wr_accept;
            ram_address = req_if.req_addr;
            ram_data    = req_if.req_wdata;
            ram_byteena = wr_accept ? req_if.req_byteena : BYTEENA_ALL;
        end
        if (rst) begin
            ram_wren    = 1'b0;
            ram_address = '0;
            ram_data    = '0;
            ram_byteena = 4'h0;
        end
    end

    assign ram_clocken = 1'b1;

    syncram_rsp_fifo #(
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clock    (clock),
        .rst      (rst),
        .push     (inflight_q),
        .push_dat (ram_q),
        .pop      (rsp_pop),
        .head_dat (req_if.rsp_data),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_syncram_client.sv
// Bench for syncram_client: behavioural RAM on the port side, array + queue
// reference model of memory contents and response order.
module tb_syncram_client;
    import syncram_client_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NW = 16;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    syncram_client_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic          ram_clocken;
    logic          ram_wren;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic [3:0]    ram_byteena;
    logic [DW-1:0] ram_q;
    logic          busy;

    syncram_client #(
        .ADDR_W(AW), .DATA_W(DW), .NUMWORDS(NW), .CLEAR_ON_RESET(1)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .req_if      (bus),
        .ram_clocken (ram_clocken),
        .ram_wren    (ram_wren),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_byteena (ram_byteena),
        .ram_q       (ram_q),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        end
        return r;
    endfunction

    // altsyncram-like model: port registered at the edge, write commits next edge,
    // q reads the registered address with new-data read-during-write.
    logic [DW-1:0] ram_mem [NW];
    logic [AW-1:0] ra_q;
    logic          rw_q;
    logic [DW-1:0] rd_q;
    logic [3:0]    rbe_q;

    always @(posedge clock) begin
        if (rw_q) ram_mem[ra_q] <= merge(ram_mem[ra_q], rd_q, rbe_q);
        ra_q  <= ram_address;
        rw_q  <= ram_wren;
        rd_q  <= ram_data;
        rbe_q <= ram_byteena;
    end
    assign ram_q = ram_mem[ra_q];

    // Reference model: memory as seen by requests, and expected responses in issue order.
    logic [31:0] ref_mem [NW];
    logic [31:0] exp_q [$];
    int          rsp_cyc_q [$];
    int          cyc = 0;

    always @(negedge clock) begin
        cyc++;
        if (rst) begin
            for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
            exp_q.delete();
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
                else check("rsp_model", bus.rsp_data, exp_q.pop_front());
                rsp_cyc_q.push_back(cyc);
            end
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_write)
                    ref_mem[bus.req_addr] = merge(ref_mem[bus.req_addr], bus.req_wdata, bus.req_byteena);
                else
                    exp_q.push_back(ref_mem[bus.req_addr]);
            end
        end
    end

    bit rand_rdy = 1'b0;

    task automatic upd_rdy();
        if (rand_rdy) bus.rsp_ready = ($urandom_range(3) != 0);
    endtask

    task automatic issue(input bit w, input int a, input logic [31:0] d, input logic [3:0] be);
        bit acc = 1'b0;
        bus.req_valid   = 1'b1;
        bus.req_write   = w;
        bus.req_addr    = AW'(a);
        bus.req_wdata   = d;
        bus.req_byteena = be;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clock);
            if (bus.req_ready) acc = 1'b1;
            else begin
                @(posedge clock); #1;
                upd_rdy();
            end
        end
        if (!acc) check("req_accept_timeout", 32'h0, 32'h1);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        upd_rdy();
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp);
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (bus.rsp_valid && bus.rsp_ready) begin
                check(tag, bus.rsp_data, exp);
                got = 1'b1;
            end
        end
        if (!got) check({tag, "_timeout"}, 32'h0, 32'h1);
        @(posedge clock); #1;
    endtask

    task automatic run_sweep(input string tag);
        int n = 0;
        for (int c = 0; c < NW + 8; c++) begin
            @(negedge clock);
            if (!busy) break;
            check({tag, "_wren"}, 32'(ram_wren), 32'h1);
            check({tag, "_addr"}, 32'(ram_address), n);
            check({tag, "_data"}, ram_data, 32'h0);
            n++;
        end
        check({tag, "_len"}, n, NW);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'h1);
        @(posedge clock); #1;
    endtask

    initial begin
        logic [31:0] got_q [$];
        int  n_acc, next_a, acc3, first_rsp, base;
        bit  took;

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_byteena = 4'h0; bus.rsp_ready = 1'b1;

        #1 rst = 1'b1;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_ram_wren", 32'(ram_wren), 32'h0);
        check("rst_ram_addr", 32'(ram_address), 32'h0);
        check("rst_ram_data", ram_data, 32'h0);
        check("rst_ram_be", 32'(ram_byteena), 32'h0);
        check("rst_clocken", 32'(ram_clocken), 32'h1);
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;
        run_sweep("sweep1");

        issue(1'b0, 5, 32'h0, 4'h0);
        wait_rsp("clr_rd5", 32'h0);

        // Write then read next cycle: new data, one-cycle latency.
        issue(1'b1, 3, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 3, 32'h0, 4'h0);
        @(negedge clock);
        check("rd_lat_early", 32'(bus.rsp_valid), 32'h0);
        @(negedge clock);
        check("rd_lat_valid", 32'(bus.rsp_valid), 32'h1);
        check("rd_after_wr", bus.rsp_data, 32'hDEADBEEF);
        @(posedge clock); #1;

        issue(1'b1, 7, 32'h11223344, 4'hF);
        issue(1'b1, 7, 32'hAABBCCDD, 4'b0101);
        issue(1'b0, 7, 32'h0, 4'h0);
        wait_rsp("bytemask", 32'h11BB33DD);

        // Streaming: eight reads back to back, eight responses on consecutive cycles.
        for (int i = 0; i < 8; i++) issue(1'b1, i, i * 32'h0101, 4'hF);
        base = rsp_cyc_q.size();
        for (int i = 0; i < 8; i++) issue(1'b0, i, 32'h0, 4'h0);
        for (int i = 0; i < 20 && rsp_cyc_q.size() < base + 8; i++) begin
            @(negedge clock); #1;
        end
        check("stream_cnt", rsp_cyc_q.size() - base, 8);
        if (rsp_cyc_q.size() >= base + 8)
            check("stream_span", rsp_cyc_q[base+7] - rsp_cyc_q[base], 7);
        @(posedge clock); #1;

        // Back-pressure: only two reads fit while the consumer stalls.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = AW'(1);
        next_a = 1; n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            took = bus.req_valid && bus.req_ready;
            if (took) n_acc++;
            @(posedge clock); #1;
            if (took) begin
                next_a++;
                bus.req_addr = AW'(next_a);
            end
        end
        check("bp_accepted", n_acc, 2);
        check("bp_ready_low", 32'(bus.req_ready), 32'h0);
        bus.rsp_ready = 1'b1;
        acc3 = -1; first_rsp = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (bus.rsp_valid && bus.rsp_ready) begin
                got_q.push_back(bus.rsp_data);
                if (first_rsp < 0) first_rsp = c;
            end
            took = bus.req_valid && bus.req_ready;
            if (took) acc3 = c;
            @(posedge clock); #1;
            if (took) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        check("bp_rsp_cnt", got_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("bp_rsp%0d", i), (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx,
                  (i + 1) * 32'h0101);
        check("bp_third_after_pop", 32'((acc3 >= 0) && (acc3 >= first_rsp)), 32'h1);

        // Randomized traffic with random consumer stalls.
        rand_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            issue(1'($urandom_range(1)), $urandom_range(NW - 1), $urandom, 4'($urandom_range(15)));
            if ($urandom_range(3) == 0) begin
                @(posedge clock); #1;
                upd_rdy();
            end
        end
        rand_rdy = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clock); #1;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clock); #1;

        // Reset with one response queued and one read in flight.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 1, 32'h0, 4'h0);
        issue(1'b0, 2, 32'h0, 4'h0);
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h1);
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;
        run_sweep("sweep2");
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("no_stale_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        @(posedge clock); #1;
        issue(1'b0, 2, 32'h0, 4'h0);
        wait_rsp("post_rst_rd", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
